// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with sequenced bulk clear
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] readnum_a,
  output logic [DATA_W-1:0] data_out_a,
  input  logic [ADDR_W-1:0] readnum_b,
  output logic [DATA_W-1:0] data_out_b,
  input  logic              clear,
  output logic              busy,
  output logic              write_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] counter;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              write_ok;
  logic              write_drop;
  logic              clear_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    write_ok    = 1'b0;
    write_drop  = 1'b0;
    clear_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear) begin
          state_nxt   = S_CLEAR;
          clear_start = 1'b1;
        end
        write_ok   = write & ~clear;
        write_drop = write & clear;
      end
      S_CLEAR: begin
        if (counter == LAST_IDX) begin
          state_nxt = S_IDLE;
        end
        write_drop = write;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter wraps naturally from LAST_IDX to 0 on the final clearing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
    end else if (clear_start) begin
      counter <= '0;
    end else if (state == S_CLEAR) begin
      counter <= counter + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[writenum] <= data_in;
    end else if (state == S_CLEAR) begin
      regs[counter] <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_err <= 1'b0;
    end else begin
      write_err <= write_drop;
    end
  end

  assign busy = (state == S_CLEAR);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    data_out_a = regs[readnum_a];
    data_out_b = regs[readnum_b];
    if (write_ok && (readnum_a == writenum)) begin
      data_out_a = data_in;
    end
    if (write_ok && (readnum_b == writenum)) begin
      data_out_b = data_in;
    end
  end
`else
  assign data_out_a = regs[readnum_a];
  assign data_out_b = regs[readnum_b];
`endif

endmodule
